// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of the byte-wide SDRAM controller: CPU (read/write)
// and video line fetch (read-only), one transaction at a time over a start/ready handshake.
module sdram_arbiter #(
   parameter int VIDEO_PRIO = 1,
   parameter int STARVE     = 4,
   parameter int TMO        = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   input  logic        vid_req,
   input  logic [31:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_rdata,
   output logic [31:0] mem_address,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_start,
   input  logic        mem_ready,
   input  logic [7:0]  mem_rdata,
   output logic        grant_vid,
   output logic        timeout
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ACK} state_t;

   localparam logic [3:0] STARVE_L = 4'(STARVE);
   localparam logic [7:0] TMO_L    = 8'(TMO);

   state_t      state, state_nx;
   logic [3:0]  run_cnt;
   logic        rr_vid;
   logic [7:0]  tmo_cnt;
   logic        pick_vid;
   logic        grant_now;
   logic        tmo_expire;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pick_vid = 1'b0;
      if (vid_req && !cpu_req)
         pick_vid = 1'b1;
      else if (vid_req && cpu_req)
         pick_vid = (VIDEO_PRIO != 0) ? (run_cnt != STARVE_L) : rr_vid;
   end

   // Requests are only considered while the controller reports idle, which also
   // covers a reset that landed in the middle of a controller transaction.
   assign grant_now  = (state == IDLE) && mem_ready && (cpu_req || vid_req);
   assign tmo_expire = (state == WAIT_LOW) && mem_ready && (tmo_cnt == 8'd1);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (grant_now) state_nx = ISSUE;
         ISSUE:     state_nx = WAIT_LOW;
         WAIT_LOW:  if (!mem_ready) state_nx = WAIT_HIGH;
                    else if (tmo_expire) state_nx = ACK;
         WAIT_HIGH: if (mem_ready) state_nx = ACK;
         ACK:       state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   assign mem_start = (state == ISSUE);
   assign cpu_ack   = (state == ACK) && !grant_vid;
   assign vid_ack   = (state == ACK) && grant_vid;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_cnt     <= '0;
         rr_vid      <= 1'b0;
         grant_vid   <= 1'b0;
         mem_address <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
      end else if (grant_now) begin
         grant_vid   <= pick_vid;
         rr_vid      <= !pick_vid;
         mem_address <= pick_vid ? vid_addr : cpu_addr;
         mem_we      <= !pick_vid && cpu_we;
         mem_wdata   <= pick_vid ? 8'h00 : cpu_wdata;
         if (pick_vid && cpu_req) begin
            if (run_cnt != STARVE_L)
               run_cnt <= run_cnt + 4'd1;
         end else begin
            run_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt   <= '0;
         timeout   <= 1'b0;
         cpu_rdata <= '0;
         vid_rdata <= '0;
      end else begin
         if (state == ISSUE)
            tmo_cnt <= TMO_L;
         else if (state == WAIT_LOW && mem_ready && tmo_cnt != 8'd0)
            tmo_cnt <= tmo_cnt - 8'd1;
         if (tmo_expire)
            timeout <= 1'b1;
         // Writes complete without touching the read-data holding registers.
         if (state == WAIT_HIGH && mem_ready && !mem_we) begin
            if (grant_vid)
               vid_rdata <= mem_rdata;
            else
               cpu_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a priority instance and a round-robin instance share
// stimulus and a behavioural SDRAM controller that follows whichever one is selected.
module tb_sdram_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
   logic [31:0] cpu_addr = '0, vid_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        mem_ready = 1'b1;
   logic [7:0]  mem_rdata = '0;
   logic        sel_rr = 1'b0;

   logic        p_cpu_ack, p_vid_ack, p_mem_we, p_mem_start, p_grant_vid, p_timeout;
   logic [7:0]  p_cpu_rdata, p_vid_rdata, p_mem_wdata;
   logic [31:0] p_mem_address;
   logic        r_cpu_ack, r_vid_ack, r_mem_we, r_mem_start, r_grant_vid, r_timeout;
   logic [7:0]  r_cpu_rdata, r_vid_rdata, r_mem_wdata;
   logic [31:0] r_mem_address;

   logic        s_cpu_ack, s_vid_ack, s_mem_we, s_mem_start, s_grant_vid, s_timeout;
   logic [7:0]  s_cpu_rdata, s_vid_rdata, s_mem_wdata;
   logic [31:0] s_mem_address;

   assign s_cpu_ack     = sel_rr ? r_cpu_ack     : p_cpu_ack;
   assign s_vid_ack     = sel_rr ? r_vid_ack     : p_vid_ack;
   assign s_mem_we      = sel_rr ? r_mem_we      : p_mem_we;
   assign s_mem_start   = sel_rr ? r_mem_start   : p_mem_start;
   assign s_grant_vid   = sel_rr ? r_grant_vid   : p_grant_vid;
   assign s_timeout     = sel_rr ? r_timeout     : p_timeout;
   assign s_cpu_rdata   = sel_rr ? r_cpu_rdata   : p_cpu_rdata;
   assign s_vid_rdata   = sel_rr ? r_vid_rdata   : p_vid_rdata;
   assign s_mem_wdata   = sel_rr ? r_mem_wdata   : p_mem_wdata;
   assign s_mem_address = sel_rr ? r_mem_address : p_mem_address;

   sdram_arbiter #(.VIDEO_PRIO(1), .STARVE(4), .TMO(8)) u_prio (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(p_vid_ack), .vid_rdata(p_vid_rdata),
      .mem_address(p_mem_address), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we),
      .mem_start(p_mem_start), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .grant_vid(p_grant_vid), .timeout(p_timeout)
   );

   sdram_arbiter #(.VIDEO_PRIO(0), .STARVE(4), .TMO(8)) u_rr (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_ack(r_cpu_ack), .cpu_rdata(r_cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(r_vid_ack), .vid_rdata(r_vid_rdata),
      .mem_address(r_mem_address), .mem_wdata(r_mem_wdata), .mem_we(r_mem_we),
      .mem_start(r_mem_start), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .grant_vid(r_grant_vid), .timeout(r_timeout)
   );

   always #5 clock = ~clock;

   // Controller model: ready falls one cycle after start, stays low mdl_busy cycles,
   // then rises with mdl_data on mem_rdata. mdl_dead models a controller that never responds.
   int          mdl_phase = 0;
   int          mdl_cnt = 0;
   int          mdl_busy = 5;
   logic        mdl_dead = 1'b0;
   logic [7:0]  mdl_data = '0;

   always @(negedge clock) begin
      case (mdl_phase)
         0: if (s_mem_start === 1'b1 && !mdl_dead) mdl_phase = 1;
         1: begin
            mem_ready = 1'b0;
            mdl_cnt   = mdl_busy;
            mdl_phase = 2;
         end
         default: begin
            if (mdl_cnt <= 1) begin
               mem_ready = 1'b1;
               mem_rdata = mdl_data;
               mdl_phase = 0;
            end else begin
               mdl_cnt = mdl_cnt - 1;
            end
         end
      endcase
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 100 && mdl_phase != 0; i++) tick();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Runs until an ack (bounded); returns in the ack cycle so rdata can be checked there.
   task automatic run_txn(input string tag, input bit drop, output bit got_vid,
                          output int n_start, output bit both_seen);
      bit done;
      done = 1'b0;
      got_vid = 1'b0;
      n_start = 0;
      both_seen = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         if (s_mem_start) n_start++;
         if (s_cpu_ack && s_vid_ack) both_seen = 1'b1;
         if (s_cpu_ack || s_vid_ack) begin
            done = 1'b1;
            got_vid = s_vid_ack;
            if (drop) begin
               cpu_req = 1'b0;
               vid_req = 1'b0;
            end
         end
      end
      check({tag, " ack seen"}, 32'(done), 32'd1);
   endtask

   typedef struct {
      logic        cpu_req, cpu_we, vid_req;
      logic [31:0] cpu_addr, vid_addr;
      logic [7:0]  cpu_wdata, rdata;
      int          busy;
      logic        exp_vid, exp_we;
      logic [31:0] exp_addr;
      logic [7:0]  exp_cpu_rdata, exp_vid_rdata;
   } vec_t;

   vec_t vecs[6];
   bit   exp_prio[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
   bit   exp_rr[4]    = '{0, 1, 0, 1};

   initial begin
      bit    got, both;
      int    ns, k;
      bit    found, early;
      string tag;

      //              creq we  vreq cpu_addr       vid_addr       wdata  rdata  busy ev ew exp_addr       crd    vrd
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0001_2345, 32'h0,         8'h00, 8'hA5, 5, 1'b0, 1'b0, 32'h0001_2345, 8'hA5, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         8'h3C, 8'hEE, 3, 1'b0, 1'b1, 32'h0000_0100, 8'hA5, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h00AB_CDEF, 8'h00, 8'h5A, 2, 1'b1, 1'b0, 32'h00AB_CDEF, 8'hA5, 8'h5A};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0010, 8'h81, 8'h77, 1, 1'b1, 1'b0, 32'h0000_0010, 8'hA5, 8'h77};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         8'h00, 8'hC3, 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'hC3, 8'h77};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0000, 8'h00, 8'h00, 8, 1'b1, 1'b0, 32'h0000_0000, 8'hC3, 8'h00};

      tick();
      do_reset();
      check("reset ctrl outputs", 32'({s_cpu_ack, s_vid_ack, s_mem_start, s_mem_we, s_grant_vid, s_timeout}), 32'd0);
      check("reset mem_address", s_mem_address, 32'd0);
      check("reset data regs", 32'({s_cpu_rdata, s_vid_rdata, s_mem_wdata}), 32'd0);

      // Single transactions from the vector table on the priority instance.
      for (int v = 0; v < 6; v++) begin
         tag = $sformatf("vec%0d", v);
         cpu_req   = vecs[v].cpu_req;
         cpu_we    = vecs[v].cpu_we;
         cpu_addr  = vecs[v].cpu_addr;
         cpu_wdata = vecs[v].cpu_wdata;
         vid_req   = vecs[v].vid_req;
         vid_addr  = vecs[v].vid_addr;
         mdl_data  = vecs[v].rdata;
         mdl_busy  = vecs[v].busy;
         run_txn(tag, 1'b1, got, ns, both);
         check({tag, " winner"}, 32'(got), 32'(vecs[v].exp_vid));
         check({tag, " start pulses"}, 32'(ns), 32'd1);
         check({tag, " acks overlap"}, 32'(both), 32'd0);
         check({tag, " mem_address"}, s_mem_address, vecs[v].exp_addr);
         check({tag, " mem_we"}, 32'(s_mem_we), 32'(vecs[v].exp_we));
         check({tag, " grant_vid"}, 32'(s_grant_vid), 32'(vecs[v].exp_vid));
         check({tag, " cpu_rdata"}, 32'(s_cpu_rdata), 32'(vecs[v].exp_cpu_rdata));
         check({tag, " vid_rdata"}, 32'(s_vid_rdata), 32'(vecs[v].exp_vid_rdata));
         if (vecs[v].exp_we)
            check({tag, " mem_wdata"}, 32'(s_mem_wdata), 32'(vecs[v].cpu_wdata));
         tick();
         check({tag, " ack one cycle"}, 32'({s_cpu_ack, s_vid_ack}), 32'd0);
      end

      // Fixed video priority with starvation guard after four video grants.
      do_reset();
      mdl_busy = 1;
      cpu_we   = 1'b0;
      cpu_req  = 1'b1;
      vid_req  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tag = $sformatf("prio%0d", i);
         run_txn(tag, i == 9, got, ns, both);
         check({tag, " winner"}, 32'(got), 32'(exp_prio[i]));
         check({tag, " grant_vid"}, 32'(s_grant_vid), 32'(exp_prio[i]));
      end
      tick();

      // Round-robin instance starts with CPU and then alternates.
      sel_rr = 1'b1;
      do_reset();
      cpu_req = 1'b1;
      vid_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tag = $sformatf("rr%0d", i);
         run_txn(tag, i == 3, got, ns, both);
         check({tag, " winner"}, 32'(got), 32'(exp_rr[i]));
         check({tag, " grant_vid"}, 32'(s_grant_vid), 32'(exp_rr[i]));
      end
      tick();

      // Controller never drops ready: timeout rises on the 8th edge after the one sampling mem_start.
      sel_rr = 1'b0;
      do_reset();
      mdl_dead = 1'b1;
      cpu_addr = 32'h0000_2000;
      cpu_req  = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = s_mem_start;
      end
      check("tmo start seen", 32'(found), 32'd1);
      check("tmo flag before expiry", 32'(s_timeout), 32'd0);
      k = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         k++;
         found = s_timeout;
      end
      check("tmo delay", 32'(k), 32'd9);
      check("tmo cpu_ack", 32'(s_cpu_ack), 32'd1);
      check("tmo cpu_rdata kept", 32'(s_cpu_rdata), 32'd0);
      cpu_req  = 1'b0;
      mdl_dead = 1'b0;
      tick();
      check("tmo ack one cycle", 32'(s_cpu_ack), 32'd0);
      mdl_data = 8'h99;
      mdl_busy = 2;
      cpu_req  = 1'b1;
      run_txn("post-tmo", 1'b1, got, ns, both);
      check("post-tmo winner", 32'(got), 32'd0);
      check("post-tmo start pulses", 32'(ns), 32'd1);
      check("post-tmo cpu_rdata", 32'(s_cpu_rdata), 32'h99);
      check("post-tmo timeout sticky", 32'(s_timeout), 32'd1);
      tick();

      // Reset during WAIT_HIGH while the controller stays busy.
      cpu_addr = 32'h0000_3000;
      mdl_data = 8'h11;
      mdl_busy = 13;
      cpu_req  = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = s_mem_start;
      end
      check("rst start seen", 32'(found), 32'd1);
      tick();
      tick();
      tick();
      mdl_data = 8'h6B;
      reset_n  = 1'b0;
      #1;
      check("rst mid ctrl outputs", 32'({s_cpu_ack, s_vid_ack, s_mem_start, s_mem_we, s_grant_vid, s_timeout}), 32'd0);
      check("rst mid mem_address", s_mem_address, 32'd0);
      check("rst mid data regs", 32'({s_cpu_rdata, s_vid_rdata, s_mem_wdata}), 32'd0);
      tick();
      reset_n = 1'b1;
      found = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (s_mem_start) begin
            found = 1'b1;
            early = (mdl_phase != 0);
         end
      end
      check("rst restart seen", 32'(found), 32'd1);
      check("rst no start while busy", 32'(early), 32'd0);
      mdl_busy = 2;
      run_txn("rst fresh", 1'b1, got, ns, both);
      check("rst fresh winner", 32'(got), 32'd0);
      check("rst fresh extra starts", 32'(ns), 32'd0);
      check("rst fresh cpu_rdata", 32'(s_cpu_rdata), 32'h6B);
      check("rst fresh mem_address", s_mem_address, 32'h0000_3000);
      check("rst fresh timeout", 32'(s_timeout), 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, expected one");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single byte-wide SDRAM controller between two requesters: the CPU port path, which handles the SDRAM address/data port registers, and the video line-fetch engine, which is read-only.
- Sits between the requesters and the SDRAM controller's start/ready handshake.
- Serialises one byte transaction at a time and returns read data with a one-cycle ack.
- Provides fixed video priority with a CPU starvation guard, or round-robin arbitration.

Parameters:
- VIDEO_PRIO, 1, 1 = video wins ties (subject to STARVE); 0 = round-robin.
- STARVE, 4, consecutive video grants allowed while cpu_req is pending; the next grant then goes to CPU (1..15).
- TMO, 255, cycles to wait in WAIT_LOW for mem_ready to fall before abandoning the transaction (1..255).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request level; held until cpu_ack.
- cpu_addr  in  32  CPU byte address.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid in the cpu_ack cycle and held until the next CPU completion.
- vid_req  in  1  video read request level; held until vid_ack.
- vid_addr  in  32  video byte address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  8  read data; valid in the vid_ack cycle and held.
- mem_address  out  32  address to the SDRAM controller.
- mem_wdata  out  8  write data to the controller.
- mem_we  out  1  write enable to the controller.
- mem_start  out  1  transaction start strobe.
- mem_ready  in  1  controller idle (1) / busy (0).
- mem_rdata  in  8  controller read data.
- grant_vid  out  1  1 while the current or last transaction belongs to video.
- timeout  out  1  sticky flag: a start was not accepted within TMO; cleared only by reset.

Behaviour:
Reset:
- All outputs go to 0 and the state goes to IDLE.
- The video-run counter and the round-robin pointer are cleared; the pointer favours CPU first.
- Reset mid-transaction does not abort the controller. The arbiter then stays in IDLE until it sees mem_ready=1.

States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ACK.

IDLE:
- Requests are ignored while mem_ready=0.
- With mem_ready=1 and at least one request, pick a winner:
  - Only one request: that requester wins.
  - Both, VIDEO_PRIO=1: video wins unless the run counter equals STARVE, in which case CPU wins.
  - Both, VIDEO_PRIO=0: the requester not granted last wins.
- Winner's address, we and wdata are latched into mem_* (video always has we=0). grant_vid is updated. Go to ISSUE.
- mem_* remain stable until the next grant.

Run counter:
- Increments on each video grant made while cpu_req=1, saturating at STARVE.
- Clears on any CPU grant, and on a video grant with cpu_req=0.

ISSUE:
- mem_start=1 for exactly one cycle. Load the TMO counter. Go to WAIT_LOW.

WAIT_LOW:
- Wait for mem_ready=0, then go to WAIT_HIGH.
- If the counter expires first: set timeout, pulse the winner's ack with rdata unchanged, go to IDLE.

WAIT_HIGH:
- On the edge where mem_ready=1: capture mem_rdata into the winner's rdata (reads only; writes leave rdata unchanged). Go to ACK.

ACK:
- Winner's ack=1 for this one cycle. Go to IDLE.
- A requester must drop req on the edge where it samples ack. A req still high in IDLE starts a new transaction.

Latency:
- Request sampled at edge N: mem_start high during cycle N+1.
- Ack is high in the cycle after the edge that sees mem_ready return to 1.
- Minimum request-to-ack time is 4 cycles plus the controller busy time.

Other rules:
- Requests arriving while not in IDLE are only evaluated at the next IDLE; there is no queueing beyond the req level.
- cpu_ack and vid_ack are never high simultaneously.
- Inputs other than the winner's are ignored during a transaction. Changes to the winner's addr/data after grant have no effect.

Test Plan:
1. CPU read only: cpu_addr=0x00012345, model drops ready 1 cycle after start and raises it 5 cycles later with data 0xA5 → mem_address=0x00012345, mem_we=0, one mem_start pulse, cpu_ack 1 cycle with cpu_rdata=0xA5, vid_ack never asserted.
2. CPU write: cpu_we=1, cpu_wdata=0x3C → mem_we=1, mem_wdata=0x3C; cpu_ack pulses and cpu_rdata keeps its prior value.
3. VIDEO_PRIO=1, STARVE=4, vid_req and cpu_req held continuously with reqs re-asserted after each ack → grant order V,V,V,V,C,V,V,V,V,C.
4. VIDEO_PRIO=0, both requesting continuously → grant order C,V,C,V; each grant_vid value matches the acked requester.
5. Model never drops ready, TMO=8 → timeout=1 exactly 8 cycles after mem_start, cpu_ack pulses, arbiter back in IDLE; a following transaction with a working model completes and timeout stays 1.
6. reset_n pulsed low during WAIT_HIGH while the model holds mem_ready=0 for 10 more cycles, cpu_req high → all outputs 0 immediately; no mem_start until mem_ready=1, then a fresh CPU transaction completes normally.
